clic_trap_ctrl: RTL
===================

Name: clic_trap_ctrl

Overview:
Testbench CSR/trap controller that sits on the retire side of the CLIC testbench instruction pipeline. It consumes retiring-instruction events (CSR writes, mret/sret, interrupt tags) and drives the fetch PC, current privilege level and pipeline flush back into the pipeline. It holds the minimal M/S trap CSR state needed to take CLIC interrupts and return from them.

Parameters:
BOOT_ADDR, 32'h0000_1000, reset fetch PC (zero-extended to XLEN)
PC_STEP, 4, sequential PC increment per cycle

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
inst_valid_i  in  1  retiring instruction valid
inst_priv_lvl_i  in  mode_t  privilege at fetch of retiring instruction (trace only)
inst_pc_i  in  xlen_t  PC of retiring instruction
irq_i  in  irq_t  interrupt tag of retiring instruction (fields: valid, id, level)
csr_write_i  in  1  retiring CSR write
csr_addr_i  in  csr_reg_t  CSR address
csr_wdata_i  in  xlen_t  CSR write data
mret_i  in  1  retiring mret
sret_i  in  1  retiring sret
pc_o  out  xlen_t  fetch PC
priv_lvl_o  out  mode_t  current privilege
flush_o  out  1  discard all in-flight pipeline stages
illegal_o  out  1  one-cycle pulse on ignored illegal event
mepc_o, mcause_o, mstatus_o  out  xlen_t  CSR observation

Behaviour:
- Reset: pc_q=BOOT_ADDR, priv=M, mstatus=0 (MIE=SIE=MPIE=SPIE=0, MPP=U, SPP=U), mtvec=stvec=mepc=sepc=mcause=scause=0, mintthresh=0; flush_o=0, illegal_o=0.
- pc_o and priv_lvl_o are register outputs. flush_o and illegal_o are combinational from the retire inputs and the current state. Every redirect takes effect at the same edge flush_o is sampled.
- Default each cycle: pc_q <= pc_q + PC_STEP (modulo 2^XLEN, wrap allowed).
- Events are evaluated only when inst_valid_i=1. Priority: interrupt > mret/sret > CSR write. The pipeline guarantees that op inputs are mutually exclusive.
- Interrupt taken iff irq_i.valid && irq_i.level > mintthresh[7:0] && (priv<M || mstatus.MIE). Enable is evaluated with CSR state at retirement, not at fetch.
- Trap entry:
  - mepc <= inst_pc_i. The instruction's own CSR/mret/sret effect is suppressed.
  - mcause <= {1'b1, zeros, irq_i.id}.
  - MPP <= priv, MPIE <= MIE, MIE <= 0, priv <= M.
  - pc_q <= {mtvec[XLEN-1:2],2'b00}; flush_o=1.
- Tagged interrupt that is not taken: the instruction retires normally and its op executes.
- mret in M: priv <= MPP, MIE <= MPIE, MPIE <= 1, MPP <= U, pc_q <= mepc, flush_o=1.
- mret in S or U: ignored, illegal_o=1, no flush.
- sret in M or S: priv <= SPP (U or S), SIE <= SPIE, SPIE <= 1, SPP <= U, pc_q <= sepc, flush_o=1.
- sret in U: ignored, illegal_o=1.
- CSR write:
  - Supported CSRs: MSTATUS, MTVEC, MEPC, MCAUSE, MINTTHRESH (M-level); SSTATUS, STVEC, SEPC, SCAUSE (S-level).
  - Write with priv below the CSR's level: ignored, illegal_o=1.
  - Unsupported address: ignored, illegal_o=1.
  - SSTATUS writes only SIE/SPIE/SPP.
  - MSTATUS writes with MPP=2'b10 (reserved) store U.
  - epc writes clear bits [1:0].
  - CSR writes do not flush; new state applies to the next retiring instruction.
- inst_valid_i=0: no state change except the PC increment, flush_o=0, illegal_o=0.
- Reset mid-operation: all state returns to reset values immediately; flush_o deasserts.

Test Plan:
- Reset, no events -> pc_o=0x1000, 0x1004, 0x1008 on successive cycles, priv=M, flush_o=0.
- Write mtvec=0x2003 and MSTATUS.MIE=1; retire irq{valid,id=5,level=8} at pc 0x1010 with mintthresh=0 -> flush_o=1 that cycle, next pc_o=0x2000, mepc=0x1010, mcause=0x8000_0005, MIE=0, MPIE=1.
- From the trap state, retire mret -> pc_o=0x1010, priv=MPP (M), MIE=1, flush_o=1.
- Set mintthresh=8, retire irq level=8 -> not taken, no flush, pc continues sequentially. Repeat with level=9 -> taken.
- MSTATUS.MPP=U, mret to U; retire CSRW MTVEC in U -> illegal_o=1, mtvec unchanged. Retire mret in U -> illegal_o=1, no flush.
- Retire irq with MIE=0 while priv=U -> taken (priv<M). Assert rst_ni low mid-trap -> pc_o=0x1000, priv=M, mepc=0.

Source files
------------

// File: rtl/clic_trap_ctrl.sv
// clic_trap_ctrl: retire-side CSR and trap controller for the CLIC testbench pipeline.
// Consumes retiring-instruction events (CSR writes, mret/sret, interrupt tags) and drives
// the fetch PC, current privilege level and pipeline flush back into the pipeline.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   inst_valid_i       retiring instruction valid
//   inst_priv_lvl_i    privilege at fetch of the retiring instruction (trace only)
//   inst_pc_i          PC of the retiring instruction
//   irq_i              interrupt tag, packed {valid, id[IRQ_ID_W-1:0], level[7:0]}
//   csr_write_i        retiring CSR write, csr_addr_i / csr_wdata_i address and data
//   mret_i, sret_i     retiring trap returns
//   pc_o, priv_lvl_o   registered fetch PC and privilege (U=00, S=01, M=11)
//   flush_o            discard all in-flight stages (combinational)
//   illegal_o          one-cycle pulse when an illegal event is ignored (combinational)
//   mepc_o, mcause_o, mstatus_o   CSR observation
module clic_trap_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_1000,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IRQ_ID_W  = 11
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inst_valid_i,
  input  logic [1:0]          inst_priv_lvl_i,
  input  logic [XLEN-1:0]     inst_pc_i,
  input  logic [IRQ_ID_W+8:0] irq_i,
  input  logic                csr_write_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [XLEN-1:0]     csr_wdata_i,
  input  logic                mret_i,
  input  logic                sret_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [1:0]          priv_lvl_o,
  output logic                flush_o,
  output logic                illegal_o,
  output logic [XLEN-1:0]     mepc_o,
  output logic [XLEN-1:0]     mcause_o,
  output logic [XLEN-1:0]     mstatus_o
);

  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivS = 2'b01;
  localparam logic [1:0] PrivM = 2'b11;

  localparam logic [11:0] CsrSstatus    = 12'h100;
  localparam logic [11:0] CsrStvec      = 12'h105;
  localparam logic [11:0] CsrSepc       = 12'h141;
  localparam logic [11:0] CsrScause     = 12'h142;
  localparam logic [11:0] CsrMstatus    = 12'h300;
  localparam logic [11:0] CsrMtvec      = 12'h305;
  localparam logic [11:0] CsrMepc       = 12'h341;
  localparam logic [11:0] CsrMcause     = 12'h342;
  localparam logic [11:0] CsrMintthresh = 12'h347;

  // Privilege at fetch is carried for tracing only; all checks use the retire-time state.
  logic unused_trace;
  assign unused_trace = ^inst_priv_lvl_i;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      priv_q, priv_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic            sie_q, sie_d, spie_q, spie_d;
  logic            spp_q, spp_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, stvec_q, stvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d, sepc_q, sepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, scause_q, scause_d;
  logic [7:0]      mintthresh_q, mintthresh_d;

  logic                irq_valid;
  logic [IRQ_ID_W-1:0] irq_id;
  logic [7:0]          irq_level;
  logic                irq_take;
  logic                csr_known, csr_mlevel, csr_ok;
  logic                flush, illegal;

  assign irq_valid = irq_i[IRQ_ID_W+8];
  assign irq_id    = irq_i[IRQ_ID_W+7:8];
  assign irq_level = irq_i[7:0];

  // Enable uses the CSR state at retirement, not the privilege at fetch.
  assign irq_take = inst_valid_i && irq_valid && (irq_level > mintthresh_q) &&
                    ((priv_q != PrivM) || mie_q);

  always_comb begin
    csr_known  = 1'b1;
    csr_mlevel = 1'b1;
    case (csr_addr_i)
      CsrMstatus, CsrMtvec, CsrMepc, CsrMcause, CsrMintthresh: csr_mlevel = 1'b1;
      CsrSstatus, CsrStvec, CsrSepc, CsrScause:                csr_mlevel = 1'b0;
      default:                                                 csr_known  = 1'b0;
    endcase
  end

  assign csr_ok = csr_known && (csr_mlevel ? (priv_q == PrivM) : (priv_q != PrivU));

  always_comb begin
    pc_d         = pc_q + XLEN'(PC_STEP);
    priv_d       = priv_q;
    mie_d        = mie_q;
    mpie_d       = mpie_q;
    sie_d        = sie_q;
    spie_d       = spie_q;
    spp_d        = spp_q;
    mpp_d        = mpp_q;
    mtvec_d      = mtvec_q;
    stvec_d      = stvec_q;
    mepc_d       = mepc_q;
    sepc_d       = sepc_q;
    mcause_d     = mcause_q;
    scause_d     = scause_q;
    mintthresh_d = mintthresh_q;
    flush        = 1'b0;
    illegal      = 1'b0;

    if (irq_take) begin
      // The interrupted instruction's own op is suppressed.
      mepc_d   = inst_pc_i;
      mcause_d = {1'b1, {(XLEN-1-IRQ_ID_W){1'b0}}, irq_id};
      mpp_d    = priv_q;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      priv_d   = PrivM;
      pc_d     = {mtvec_q[XLEN-1:2], 2'b00};
      flush    = 1'b1;
    end else if (inst_valid_i && mret_i) begin
      if (priv_q == PrivM) begin
        priv_d = mpp_q;
        mie_d  = mpie_q;
        mpie_d = 1'b1;
        mpp_d  = PrivU;
        pc_d   = mepc_q;
        flush  = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else if (inst_valid_i && sret_i) begin
      if (priv_q != PrivU) begin
        priv_d = spp_q ? PrivS : PrivU;
        sie_d  = spie_q;
        spie_d = 1'b1;
        spp_d  = 1'b0;
        pc_d   = sepc_q;
        flush  = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else if (inst_valid_i && csr_write_i) begin
      if (!csr_ok) begin
        illegal = 1'b1;
      end else begin
        case (csr_addr_i)
          CsrMstatus: begin
            sie_d  = csr_wdata_i[1];
            mie_d  = csr_wdata_i[3];
            spie_d = csr_wdata_i[5];
            mpie_d = csr_wdata_i[7];
            spp_d  = csr_wdata_i[8];
            // MPP=2'b10 is reserved and collapses to U.
            mpp_d  = (csr_wdata_i[12:11] == 2'b10) ? PrivU : csr_wdata_i[12:11];
          end
          CsrSstatus: begin
            sie_d  = csr_wdata_i[1];
            spie_d = csr_wdata_i[5];
            spp_d  = csr_wdata_i[8];
          end
          CsrMtvec:      mtvec_d      = csr_wdata_i;
          CsrStvec:      stvec_d      = csr_wdata_i;
          CsrMepc:       mepc_d       = {csr_wdata_i[XLEN-1:2], 2'b00};
          CsrSepc:       sepc_d       = {csr_wdata_i[XLEN-1:2], 2'b00};
          CsrMcause:     mcause_d     = csr_wdata_i;
          CsrScause:     scause_d     = csr_wdata_i;
          CsrMintthresh: mintthresh_d = csr_wdata_i[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= XLEN'(BOOT_ADDR);
      priv_q       <= PrivM;
      mie_q        <= 1'b0;
      mpie_q       <= 1'b0;
      sie_q        <= 1'b0;
      spie_q       <= 1'b0;
      spp_q        <= 1'b0;
      mpp_q        <= PrivU;
      mtvec_q      <= '0;
      stvec_q      <= '0;
      mepc_q       <= '0;
      sepc_q       <= '0;
      mcause_q     <= '0;
      scause_q     <= '0;
      mintthresh_q <= '0;
    end else begin
      pc_q         <= pc_d;
      priv_q       <= priv_d;
      mie_q        <= mie_d;
      mpie_q       <= mpie_d;
      sie_q        <= sie_d;
      spie_q       <= spie_d;
      spp_q        <= spp_d;
      mpp_q        <= mpp_d;
      mtvec_q      <= mtvec_d;
      stvec_q      <= stvec_d;
      mepc_q       <= mepc_d;
      sepc_q       <= sepc_d;
      mcause_q     <= mcause_d;
      scause_q     <= scause_d;
      mintthresh_q <= mintthresh_d;
    end
  end

  // Outputs are gated so a flush or illegal pulse never escapes while reset is held.
  assign flush_o    = flush & rst_ni;
  assign illegal_o  = illegal & rst_ni;
  assign pc_o       = pc_q;
  assign priv_lvl_o = priv_q;
  assign mepc_o     = mepc_q;
  assign mcause_o   = mcause_q;

  always_comb begin
    mstatus_o        = '0;
    mstatus_o[1]     = sie_q;
    mstatus_o[3]     = mie_q;
    mstatus_o[5]     = spie_q;
    mstatus_o[7]     = mpie_q;
    mstatus_o[8]     = spp_q;
    mstatus_o[12:11] = mpp_q;
  end

endmodule
